// File: rtl/dmem_access_unit.sv
// Data-memory stage: runs one valid/ready bus transaction per load/store, aligns and
// extends load data, and holds the pipeline with stall until the response has arrived.
module dmem_access_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              memr,
  input  logic              memw,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              flush,
  input  logic              pipe_advance,
  output logic              stall,
  output logic [XLEN-1:0]   dmem_data,
  output logic              misaligned,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [XLEN-1:0]   req_wdata,
  output logic [7:0]        req_wstrb,
  input  logic              resp_valid,
  input  logic [XLEN-1:0]   resp_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2, S_DONE = 2'd3} state_t;

  // Bus handshake: a request transfers on the rising edge where req_valid and req_ready
  // are both 1; req_* fields hold steady while req_valid waits. resp_valid is a one-cycle
  // strobe that is only honoured while a response is outstanding.

  state_t            r_state, w_next;
  logic              r_req_we, r_is_load, r_flushed;
  logic [ADDR_W-1:0] r_req_addr;
  logic [XLEN-1:0]   r_req_wdata, r_dmem_data;
  logic [7:0]        r_req_wstrb;
  logic [2:0]        r_off, r_funct3;

  logic              w_mis_sz, w_mem_op;
  logic [2:0]        w_off;
  logic [7:0]        w_strb;
  logic [XLEN-1:0]   w_raw, w_ld, w_capture;

  assign w_off = addr[2:0];

  always_comb begin
    w_mis_sz = 1'b0;
    w_strb   = 8'hFF;
    case (funct3[1:0])
      2'b00:   begin w_mis_sz = 1'b0;        w_strb = 8'h01 << w_off; end
      2'b01:   begin w_mis_sz = addr[0];     w_strb = 8'h03 << w_off; end
      2'b10:   begin w_mis_sz = |addr[1:0];  w_strb = 8'h0F << w_off; end
      default: begin w_mis_sz = |addr[2:0];  w_strb = 8'hFF;          end
    endcase
  end

  assign misaligned = valid_in & (memr | memw) & w_mis_sz;
  assign w_mem_op   = valid_in & (memr | memw) & ~misaligned & ~flush;
  // rst gates stall so an asynchronous reset releases the pipeline without a clock edge.
  assign stall      = w_mem_op & (r_state != S_DONE) & ~rst;
  // A flushed request is withdrawn in the same cycle so the bus can never accept it.
  assign req_valid  = (r_state == S_REQ) & ~flush;
  assign req_we     = r_req_we;
  assign req_addr   = r_req_addr;
  assign req_wdata  = r_req_wdata;
  assign req_wstrb  = r_req_wstrb;
  assign dmem_data  = r_dmem_data;
  assign dbg_state  = r_state;

  always_comb begin
    w_raw = resp_data >> {r_off, 3'b000};
    w_ld  = w_raw;
    case (r_funct3[1:0])
      2'b00:   w_ld = {{56{~r_funct3[2] & w_raw[7]}},  w_raw[7:0]};
      2'b01:   w_ld = {{48{~r_funct3[2] & w_raw[15]}}, w_raw[15:0]};
      2'b10:   w_ld = {{32{~r_funct3[2] & w_raw[31]}}, w_raw[31:0]};
      default: w_ld = w_raw;
    endcase
    w_capture = (r_is_load & ~r_flushed & ~flush) ? w_ld : '0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mem_op) w_next = S_REQ;
      S_REQ:   if (flush) w_next = S_IDLE;
               else if (req_ready) w_next = S_RESP;
      S_RESP:  if (resp_valid) w_next = S_DONE;
      default: if (pipe_advance) w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
      r_off       <= '0;
      r_funct3    <= '0;
      r_is_load   <= 1'b0;
      r_flushed   <= 1'b0;
      r_dmem_data <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_mem_op) begin
          r_req_we    <= memw;
          r_req_addr  <= {addr[ADDR_W-1:3], 3'b000};
          r_req_wdata <= memw ? (wdata << {w_off, 3'b000}) : '0;
          r_req_wstrb <= memw ? w_strb : 8'h00;
          r_off       <= w_off;
          r_funct3    <= funct3;
          r_is_load   <= memr;
          r_flushed   <= 1'b0;
          r_dmem_data <= '0;
        end
        S_RESP: begin
          if (flush) r_flushed <= 1'b1;
          if (resp_valid) r_dmem_data <= w_capture;
        end
        S_DONE: if (pipe_advance) r_dmem_data <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a small bus responder answers requests, expected
// load data is queued when an op is issued and compared when the unit reaches DONE.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst, valid_in, memr, memw, flush, pipe_advance;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata, dmem_data, req_addr, req_wdata, resp_data;
  logic        stall, misaligned, req_valid, req_ready, req_we, resp_valid;
  logic [7:0]  req_wstrb;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  logic        st_we;
  logic [7:0]  st_strb;
  logic [63:0] st_wdata, st_addr;

  always #5 clk = ~clk;

  dmem_access_unit #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .memr(memr), .memw(memw),
    .funct3(funct3), .addr(addr), .wdata(wdata), .flush(flush),
    .pipe_advance(pipe_advance), .stall(stall), .dmem_data(dmem_data),
    .misaligned(misaligned), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_data(resp_data),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_scoreboard(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) e = 64'hBAD0_BAD0_BAD0_BAD0;
    else e = exp_q.pop_front();
    chk({tag, " dmem_data"}, dmem_data, e);
  endtask

  // Issues one op and plays the bus: ready after ready_wait REQ cycles, response one
  // cycle after acceptance. Checks stall length, req_valid span and the load result.
  task automatic run_op(input string tag, input logic mr, input logic mw,
                        input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rd,
                        input int ready_wait);
    int   cyc, waited, rv_cyc;
    logic acc;
    logic [63:0] exp_addr;
    valid_in = 1'b1; memr = mr; memw = mw; funct3 = f3; addr = a; wdata = wd;
    exp_addr = {a[63:3], 3'b000};
    cyc = 0; waited = 0; rv_cyc = 0; acc = 1'b0;
    #1;
    while (stall && cyc < 60) begin
      cyc++;
      resp_valid = acc;
      resp_data  = acc ? rd : 64'h0;
      acc        = 1'b0;
      req_ready  = 1'b0;
      if (req_valid) begin
        rv_cyc++;
        st_we = req_we; st_strb = req_wstrb; st_wdata = req_wdata;
        if (req_addr !== exp_addr) st_addr = req_addr;
        if (waited >= ready_wait) begin
          req_ready = 1'b1;
          acc       = 1'b1;
        end else begin
          waited++;
        end
      end
      tick();
    end
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    chk({tag, " stall cycles"}, 64'(cyc), 64'(3 + ready_wait));
    chk({tag, " req_valid cycles"}, 64'(rv_cyc), 64'(1 + ready_wait));
    chk({tag, " state done"}, 64'(dbg_state), 64'd3);
    chk_scoreboard(tag);
    pipe_advance = 1'b1;
    tick();
    pipe_advance = 1'b0;
    valid_in = 1'b0; memr = 1'b0; memw = 1'b0;
    #1;
  endtask

  initial begin
    logic rv_seen;
    rst = 1'b1; valid_in = 1'b0; memr = 1'b0; memw = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; flush = 1'b0; pipe_advance = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    st_we = 1'b0; st_strb = '0; st_wdata = '0; st_addr = '0;
    tick(); tick();
    chk("rst stall", stall, 0);
    chk("rst dmem_data", dmem_data, 0);
    chk("rst req_valid", req_valid, 0);
    chk("rst req_we", req_we, 0);
    chk("rst req_addr", req_addr, 0);
    chk("rst req_wdata", req_wdata, 0);
    chk("rst req_wstrb", req_wstrb, 0);
    chk("rst state", dbg_state, 0);
    rst = 1'b0;
    tick();

    exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
    run_op("LB", 1, 0, 3'b000, 64'h1003, 0, 64'h0000_0000_80FF_0000, 0);
    exp_q.push_back(64'h0000_0000_0000_0080);
    run_op("LBU", 1, 0, 3'b100, 64'h1003, 0, 64'h0000_0000_80FF_0000, 0);

    st_addr = 64'h2000;
    exp_q.push_back(64'h0);
    run_op("SH", 0, 1, 3'b001, 64'h2006, 64'hABCD, 64'hDEAD_BEEF, 0);
    chk("SH req_we", st_we, 1);
    chk("SH req_addr", st_addr, 64'h2000);
    chk("SH req_wstrb", st_strb, 8'hC0);
    chk("SH req_wdata hi", st_wdata[63:48], 16'hABCD);

    exp_q.push_back(64'h0);
    run_op("SW", 0, 1, 3'b010, 64'h6004, 64'h1234_5678, 64'h0, 0);
    chk("SW req_wstrb", st_strb, 8'hF0);
    chk("SW req_wdata", st_wdata, 64'h1234_5678_0000_0000);

    st_addr = 64'h4008;
    exp_q.push_back(64'h1122_3344_5566_7788);
    run_op("LD wait", 1, 0, 3'b011, 64'h4008, 0, 64'h1122_3344_5566_7788, 5);
    chk("LD wait req_addr stable", st_addr, 64'h4008);

    exp_q.push_back(64'h0000_0000_0000_8001);
    run_op("LHU", 1, 0, 3'b101, 64'h5006, 0, 64'h8001_0000_0000_0000, 0);
    exp_q.push_back(64'hFFFF_FFFF_F000_0000);
    run_op("LW", 1, 0, 3'b010, 64'h5004, 0, 64'hF000_0000_0000_0000, 1);

    // misaligned word load: no stall, no request
    valid_in = 1'b1; memr = 1'b1; funct3 = 3'b010; addr = 64'h3002;
    #1;
    chk("MIS misaligned", misaligned, 1);
    chk("MIS stall", stall, 0);
    rv_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_ready = 1'b1;
      tick();
      if (req_valid) rv_seen = 1'b1;
    end
    req_ready = 1'b0;
    chk("MIS req_valid seen", rv_seen, 0);
    valid_in = 1'b0; memr = 1'b0;
    tick();

    // flush while the request is pending
    valid_in = 1'b1; memr = 1'b1; funct3 = 3'b011; addr = 64'h7000;
    tick();
    chk("FLREQ state req", dbg_state, 1);
    flush = 1'b1;
    tick();
    chk("FLREQ state idle", dbg_state, 0);
    chk("FLREQ req_valid", req_valid, 0);
    flush = 1'b0; valid_in = 1'b0; memr = 1'b0;
    tick();

    // flush while waiting for the response: bus completes, data forced to 0
    valid_in = 1'b1; memr = 1'b1; funct3 = 3'b010; addr = 64'h7010;
    tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("FLRESP state resp", dbg_state, 2);
    flush = 1'b1;
    exp_q.push_back(64'h0);
    tick();
    flush = 1'b0; valid_in = 1'b0; memr = 1'b0;
    resp_valid = 1'b1; resp_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    resp_valid = 1'b0;
    chk("FLRESP state done", dbg_state, 3);
    chk_scoreboard("FLRESP");
    pipe_advance = 1'b1;
    tick();
    pipe_advance = 1'b0;
    chk("FLRESP back idle", dbg_state, 0);

    // asynchronous reset while the response is outstanding
    valid_in = 1'b1; memr = 1'b1; funct3 = 3'b011; addr = 64'h8000;
    tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("RST state resp", dbg_state, 2);
    rst = 1'b1;
    #1;
    chk("RST req_valid", req_valid, 0);
    chk("RST stall", stall, 0);
    chk("RST state", dbg_state, 0);
    tick();
    rst = 1'b0; valid_in = 1'b0; memr = 1'b0;
    resp_valid = 1'b1; resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    resp_valid = 1'b0;
    tick();
    chk("RST late resp state", dbg_state, 0);
    chk("RST late resp data", dmem_data, 0);

    chk("scoreboard drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
